dcache_snoop_responder: RTL and testbench

Coherence-side responder for the 2-way, 2-word-block data cache.
- Accepts one snoop request from the coherence controller and looks up the snooped block in both ways of the indexed set.
- On a dirty hit, writes both words back to memory. Then invalidates the block (ccinv) or cleans it (read snoop, M->S).
- Drives the per-way inv and dirty-clear strobes of the cache block storage.
- Sits beside the main dcache controller, which stalls while busy=1.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/dcache_snoop_responder_if.sv | 49 ++++
 rtl/dcache_snoop_responder_tag_cmp.sv | 46 ++++
 rtl/dcache_snoop_responder.sv | 140 ++++++++++++++
 tb/tb_dcache_snoop_responder.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared cache types for the data-cache snoop path: address layout,
// default geometry and the snoop responder state encoding.
package cpu_types_pkg;

  localparam int DIDX_W = 3;
  localparam int DTAG_W = 26;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB0     = 3'd2,
    WB1     = 3'd3,
    UPDATE  = 3'd4,
    RELEASE = 3'd5
  } snoop_state_t;

  // Byte address as seen by the data cache: tag | set | word | byte.
  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

endpackage

// File: rtl/dcache_snoop_responder_if.sv
// Bundle of the coherence request, cache-array snoop port and memory
// write port used by the snoop responder. master = responder side.
interface dcache_snoop_responder_if
  import cpu_types_pkg::*;
#(
  parameter int IDX_W = DIDX_W,
  parameter int TAG_W = DTAG_W
) ();

  logic             ccwait;
  logic             ccinv;
  logic [31:0]      ccsnoopaddr;
  logic [IDX_W-1:0] snp_idx;
  logic [TAG_W-1:0] snp_tag0;
  logic [TAG_W-1:0] snp_tag1;
  logic             snp_valid0;
  logic             snp_valid1;
  logic             snp_dirty0;
  logic             snp_dirty1;
  logic             snp_way;
  logic             snp_rBO;
  logic [31:0]      snp_data;
  logic [1:0]       snp_inv;
  logic [1:0]       snp_clean;
  logic             ccwrite;
  logic             cctrans;
  logic             dWEN;
  logic [31:0]      daddr;
  logic [31:0]      dstore;
  logic             dwait;
  logic             busy;

  modport master (
    input  ccwait, ccinv, ccsnoopaddr,
    input  snp_tag0, snp_tag1, snp_valid0, snp_valid1, snp_dirty0, snp_dirty1, snp_data,
    input  dwait,
    output snp_idx, snp_way, snp_rBO, snp_inv, snp_clean,
    output ccwrite, cctrans, dWEN, daddr, dstore, busy
  );

  modport slave (
    output ccwait, ccinv, ccsnoopaddr,
    output snp_tag0, snp_tag1, snp_valid0, snp_valid1, snp_dirty0, snp_dirty1, snp_data,
    output dwait,
    input  snp_idx, snp_way, snp_rBO, snp_inv, snp_clean,
    input  ccwrite, cctrans, dWEN, daddr, dstore, busy
  );

endinterface

// File: rtl/dcache_snoop_responder_tag_cmp.sv
// Two-way tag compare for a snooped set. Way 0 takes priority if both
// ways report a hit, which should never happen in a coherent cache.
module snoop_tag_cmp
  import cpu_types_pkg::*;
#(
  parameter int TAG_W = DTAG_W
) (
  input  logic [TAG_W-1:0] i_tag,
  input  logic [TAG_W-1:0] i_tag0,
  input  logic [TAG_W-1:0] i_tag1,
  input  logic             i_valid0,
  input  logic             i_valid1,
  input  logic             i_dirty0,
  input  logic             i_dirty1,
  output logic             o_hit,
  output logic             o_way,
  output logic             o_dirty
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_valid0 && (i_tag0 == i_tag);
  assign w_hit1 = i_valid1 && (i_tag1 == i_tag);

  // Select the hitting way and report its dirty bit.
  always_comb begin
    o_hit   = 1'b0;
    o_way   = 1'b0;
    o_dirty = 1'b0;
    if (w_hit0) begin
      o_hit   = 1'b1;
      o_way   = 1'b0;
      o_dirty = i_dirty0;
    end else if (w_hit1) begin
      o_hit   = 1'b1;
      o_way   = 1'b1;
      o_dirty = i_dirty1;
    end else begin
      o_hit   = 1'b0;
      o_way   = 1'b0;
      o_dirty = 1'b0;
    end
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Coherence-side snoop responder for the 2-way, 2-word-block data cache.
// Looks up the snooped block, writes back dirty data, then invalidates
// (BusRdX) or cleans (BusRd) the line. TAG_W + IDX_W + 3 must equal 32.
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int IDX_W = DIDX_W,
  parameter int TAG_W = DTAG_W
) (
  input logic                     CLK,
  input logic                     nRST,
  dcache_snoop_responder_if.master bus
);

  snoop_state_t     r_state;
  snoop_state_t     w_next_state;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic             r_inv;
  logic             r_way;
  logic             w_hit;
  logic             w_way;
  logic             w_dirty;
  logic [2:0]       w_unused_low;

  // Word/byte offset of the snoop address is irrelevant: whole block is handled.
  assign w_unused_low = bus.ccsnoopaddr[2:0];

  snoop_tag_cmp #(.TAG_W(TAG_W)) u_tag_cmp (
    .i_tag    (r_tag),
    .i_tag0   (bus.snp_tag0),
    .i_tag1   (bus.snp_tag1),
    .i_valid0 (bus.snp_valid0),
    .i_valid1 (bus.snp_valid1),
    .i_dirty0 (bus.snp_dirty0),
    .i_dirty1 (bus.snp_dirty1),
    .o_hit    (w_hit),
    .o_way    (w_way),
    .o_dirty  (w_dirty)
  );

  // State register plus request latch (IDLE only) and hit-way capture.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_tag   <= {TAG_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_inv   <= 1'b0;
      r_way   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && bus.ccwait) begin
        r_tag <= bus.ccsnoopaddr[31 -: TAG_W];
        r_idx <= bus.ccsnoopaddr[IDX_W+2:3];
        r_inv <= bus.ccinv;
      end
      if ((r_state == LOOKUP) && w_hit) begin
        r_way <= w_way;
      end
    end
  end

  // Next-state and output decode; every output idles at zero.
  always_comb begin
    w_next_state  = r_state;
    bus.busy      = 1'b0;
    bus.snp_idx   = {IDX_W{1'b0}};
    bus.snp_way   = 1'b0;
    bus.snp_rBO   = 1'b0;
    bus.snp_inv   = 2'b00;
    bus.snp_clean = 2'b00;
    bus.ccwrite   = 1'b0;
    bus.cctrans   = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = 32'h0000_0000;
    bus.dstore    = 32'h0000_0000;
    case (r_state)
      IDLE: begin
        if (bus.ccwait) begin
          w_next_state = LOOKUP;
        end else begin
          w_next_state = IDLE;
        end
      end
      LOOKUP: begin
        bus.busy    = 1'b1;
        bus.snp_idx = r_idx;
        if (w_hit && w_dirty) begin
          bus.cctrans  = 1'b1;
          bus.ccwrite  = 1'b1;
          w_next_state = WB0;
        end else if (w_hit && r_inv) begin
          bus.cctrans  = 1'b1;
          w_next_state = UPDATE;
        end else begin
          w_next_state = RELEASE;
        end
      end
      WB0, WB1: begin
        bus.busy    = 1'b1;
        bus.snp_idx = r_idx;
        bus.ccwrite = 1'b1;
        bus.dWEN    = 1'b1;
        bus.snp_way = r_way;
        bus.snp_rBO = (r_state == WB1);
        bus.daddr   = {r_tag, r_idx, (r_state == WB1), 2'b00};
        bus.dstore  = bus.snp_data;
        if (bus.dwait) begin
          w_next_state = r_state;
        end else if (r_state == WB0) begin
          w_next_state = WB1;
        end else begin
          w_next_state = UPDATE;
        end
      end
      UPDATE: begin
        bus.busy    = 1'b1;
        bus.snp_idx = r_idx;
        if (r_inv) begin
          bus.snp_inv = r_way ? 2'b10 : 2'b01;
        end else begin
          bus.snp_clean = r_way ? 2'b10 : 2'b01;
        end
        w_next_state = RELEASE;
      end
      RELEASE: begin
        bus.busy = 1'b1;
        if (bus.ccwait) begin
          w_next_state = RELEASE;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench for dcache_snoop_responder: a small cache/memory model
// answers the snoop port, expected memory writes are queued and compared.
module tb_dcache_snoop_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  dcache_snoop_responder_if #(.IDX_W(DIDX_W), .TAG_W(DTAG_W)) bus ();
  dcache_snoop_responder #(.IDX_W(DIDX_W), .TAG_W(DTAG_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];

  // cache array model
  logic [DTAG_W-1:0] tag_m  [0:1][0:7];
  logic              v_m    [0:1][0:7];
  logic              d_m    [0:1][0:7];
  logic [31:0]       data_m [0:1][0:7][0:1];

  assign bus.snp_tag0   = tag_m[0][bus.snp_idx];
  assign bus.snp_tag1   = tag_m[1][bus.snp_idx];
  assign bus.snp_valid0 = v_m[0][bus.snp_idx];
  assign bus.snp_valid1 = v_m[1][bus.snp_idx];
  assign bus.snp_dirty0 = d_m[0][bus.snp_idx];
  assign bus.snp_dirty1 = d_m[1][bus.snp_idx];
  assign bus.snp_data   = data_m[bus.snp_way][bus.snp_idx][bus.snp_rBO];

  // monitor state
  int cyc = 0, wait_n = 0, wcnt = 0;
  int n_cctrans, n_ccwrite, n_dwen, n_inv, n_clean, n_busy_rise, n_wr;
  int lookup_cyc, inv_cyc, clean_cyc, cctrans_cyc;
  logic [1:0] inv_val, clean_val;
  logic prev_busy = 1'b0, prev_hold = 1'b0;
  logic [31:0] prev_daddr, prev_dstore;

  // Memory model, write scoreboard and event counters, all on the falling edge.
  always @(negedge CLK) begin
    wr_t w;
    cyc++;
    if (bus.dWEN === 1'b1) begin
      if (wcnt < wait_n) begin bus.dwait = 1'b1; wcnt++; end
      else begin bus.dwait = 1'b0; wcnt = 0; end
    end else begin
      bus.dwait = 1'b0; wcnt = 0;
    end
    if ((bus.dWEN === 1'b1) && prev_hold) begin
      checks++;
      if ((bus.daddr !== prev_daddr) || (bus.dstore !== prev_dstore)) begin
        errors++;
        $display("FAIL wait_stable: got %h/%h expected %h/%h", bus.daddr, bus.dstore, prev_daddr, prev_dstore);
      end
    end
    prev_hold   = (bus.dWEN === 1'b1) && bus.dwait;
    prev_daddr  = bus.daddr;
    prev_dstore = bus.dstore;
    if ((bus.dWEN === 1'b1) && !bus.dwait) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h<-%h expected no write", bus.daddr, bus.dstore);
      end else begin
        w = exp_q.pop_front();
        if ((bus.daddr !== w.addr) || (bus.dstore !== w.data)) begin
          errors++;
          $display("FAIL mem_write: got %h<-%h expected %h<-%h", bus.daddr, bus.dstore, w.addr, w.data);
        end
      end
    end
    if (bus.dWEN === 1'b1) n_dwen++;
    if (bus.ccwrite === 1'b1) n_ccwrite++;
    if (bus.cctrans === 1'b1) begin n_cctrans++; cctrans_cyc = cyc; end
    if ((bus.snp_inv !== 2'b00) && (bus.snp_clean !== 2'b00)) begin
      checks++; errors++;
      $display("FAIL strobe_excl: got inv=%b clean=%b expected one of them zero", bus.snp_inv, bus.snp_clean);
    end
    if (bus.snp_inv === 2'b01 || bus.snp_inv === 2'b10) begin
      n_inv++; inv_val = bus.snp_inv; inv_cyc = cyc;
      v_m[bus.snp_inv[1]][bus.snp_idx] = 1'b0;
      d_m[bus.snp_inv[1]][bus.snp_idx] = 1'b0;
    end else if (bus.snp_inv !== 2'b00 && bus.snp_inv !== 2'bxx) begin
      n_inv++; inv_val = bus.snp_inv;
    end
    if (bus.snp_clean === 2'b01 || bus.snp_clean === 2'b10) begin
      n_clean++; clean_val = bus.snp_clean; clean_cyc = cyc;
      d_m[bus.snp_clean[1]][bus.snp_idx] = 1'b0;
    end else if (bus.snp_clean !== 2'b00 && bus.snp_clean !== 2'bxx) begin
      n_clean++; clean_val = bus.snp_clean;
    end
    if ((bus.busy === 1'b1) && !prev_busy) begin n_busy_rise++; lookup_cyc = cyc; end
    prev_busy = (bus.busy === 1'b1);
  end

  task automatic clear_stats();
    n_cctrans = 0; n_ccwrite = 0; n_dwen = 0; n_inv = 0; n_clean = 0;
    n_busy_rise = 0; n_wr = 0;
    lookup_cyc = -100; inv_cyc = -1; clean_cyc = -1; cctrans_cyc = -1;
    inv_val = 2'b00; clean_val = 2'b00;
    exp_q.delete();
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        tag_m[w][s] = '0; v_m[w][s] = 1'b0; d_m[w][s] = 1'b0;
        data_m[w][s][0] = 32'h0; data_m[w][s][1] = 32'h0;
      end
  endtask

  task automatic set_line(input int w, input int s, input logic [DTAG_W-1:0] t,
                          input logic v, input logic d, input logic [31:0] d0, input logic [31:0] d1);
    tag_m[w][s] = t; v_m[w][s] = v; d_m[w][s] = d;
    data_m[w][s][0] = d0; data_m[w][s][1] = d1;
  endtask

  // Raise ccwait with addr/inv, then scribble on both so late changes show up.
  task automatic run_snoop(input logic [31:0] addr, input logic inv, input int hold);
    @(negedge CLK);
    bus.ccwait = 1'b1; bus.ccsnoopaddr = addr; bus.ccinv = inv;
    @(negedge CLK);
    bus.ccsnoopaddr = 32'hFFFF_FFFC; bus.ccinv = ~inv;
    repeat (hold) @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bus.busy, bus.dWEN, bus.ccwrite, bus.cctrans, bus.snp_inv, bus.snp_clean} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
                         {bus.busy, bus.dWEN, bus.ccwrite, bus.cctrans, bus.snp_inv, bus.snp_clean});
    end
    checks++;
    if ({bus.daddr, bus.dstore} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h %h expected 0 0", bus.daddr, bus.dstore);
    end
    nRST = 1'b1;
  endtask

  task automatic test_reset_mid_wb();
    bit seen = 0;
    clear_model(); clear_stats();
    set_line(1, 1, 26'h69, 1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0004);
    wait_n = 1000;
    @(negedge CLK);
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h0000_1A48; bus.ccinv = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (bus.dWEN === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_wb_reach: got no dWEN expected dWEN within 10 cycles"); end
    nRST = 1'b0; bus.ccwait = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.dWEN, bus.ccwrite, bus.busy} !== 3'b000) begin
      errors++; $display("FAIL rst_wb_outputs: got dWEN,ccwrite,busy=%b expected 000", {bus.dWEN, bus.ccwrite, bus.busy});
    end
    nRST = 1'b1; wait_n = 0;
    repeat (4) @(negedge CLK);
    checks++;
    if ((n_inv != 0) || (n_clean != 0) || (bus.busy !== 1'b0)) begin
      errors++; $display("FAIL rst_wb_nostrobe: got inv=%0d clean=%0d busy=%b expected 0 0 0", n_inv, n_clean, bus.busy);
    end
  endtask

  task automatic test_dirty_read();
    clear_model(); clear_stats();
    set_line(1, 1, 26'h69, 1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0004);
    wait_n = 0;
    exp_q.push_back('{32'h0000_1A48, 32'hDEAD0000});
    exp_q.push_back('{32'h0000_1A4C, 32'hDEAD0004});
    run_snoop(32'h0000_1A48, 1'b0, 10);
    checks++;
    if (n_wr != 2 || exp_q.size() != 0) begin errors++; $display("FAIL dr_writes: got %0d expected 2", n_wr); end
    checks++;
    if (n_ccwrite != 3) begin errors++; $display("FAIL dr_ccwrite: got %0d cycles expected 3", n_ccwrite); end
    checks++;
    if (n_cctrans != 1 || cctrans_cyc != lookup_cyc) begin
      errors++; $display("FAIL dr_cctrans: got %0d at %0d expected 1 at %0d", n_cctrans, cctrans_cyc, lookup_cyc);
    end
    checks++;
    if (n_clean != 1 || clean_val !== 2'b10 || clean_cyc != lookup_cyc + 3) begin
      errors++; $display("FAIL dr_clean: got %0d x %b at +%0d expected 1 x 10 at +3", n_clean, clean_val, clean_cyc - lookup_cyc);
    end
    checks++;
    if (n_inv != 0) begin errors++; $display("FAIL dr_noinv: got %0d expected 0", n_inv); end
    bus.ccwait = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_dirty_inv_wait();
    clear_model(); clear_stats();
    set_line(1, 1, 26'h69, 1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0004);
    wait_n = 3;
    exp_q.push_back('{32'h0000_1A48, 32'hDEAD0000});
    exp_q.push_back('{32'h0000_1A4C, 32'hDEAD0004});
    run_snoop(32'h0000_1A48, 1'b1, 16);
    checks++;
    if (n_wr != 2 || exp_q.size() != 0) begin errors++; $display("FAIL di_writes: got %0d expected 2", n_wr); end
    checks++;
    if (n_dwen != 8 || n_ccwrite != 9) begin
      errors++; $display("FAIL di_hold: got dWEN=%0d ccwrite=%0d expected 8 9", n_dwen, n_ccwrite);
    end
    checks++;
    if (n_inv != 1 || inv_val !== 2'b10 || inv_cyc != lookup_cyc + 9) begin
      errors++; $display("FAIL di_inv: got %0d x %b at +%0d expected 1 x 10 at +9", n_inv, inv_val, inv_cyc - lookup_cyc);
    end
    checks++;
    if (n_clean != 0) begin errors++; $display("FAIL di_noclean: got %0d expected 0", n_clean); end
    wait_n = 0;
    bus.ccwait = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_clean_inv();
    clear_model(); clear_stats();
    set_line(0, 0, 26'h4, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222);
    run_snoop(32'h0000_0100, 1'b1, 6);
    checks++;
    if (n_dwen != 0 || n_ccwrite != 0) begin
      errors++; $display("FAIL ci_nowb: got dWEN=%0d ccwrite=%0d expected 0 0", n_dwen, n_ccwrite);
    end
    checks++;
    if (n_cctrans != 1 || cctrans_cyc != lookup_cyc) begin
      errors++; $display("FAIL ci_cctrans: got %0d at +%0d expected 1 at +0", n_cctrans, cctrans_cyc - lookup_cyc);
    end
    checks++;
    if (n_inv != 1 || inv_val !== 2'b01 || inv_cyc != lookup_cyc + 1) begin
      errors++; $display("FAIL ci_inv: got %0d x %b at +%0d expected 1 x 01 at +1", n_inv, inv_val, inv_cyc - lookup_cyc);
    end
    bus.ccwait = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_miss();
    for (int k = 0; k < 2; k++) begin
      clear_model(); clear_stats();
      if (k == 0) set_line(1, 1, 26'h69, 1'b0, 1'b1, 32'hA, 32'hB);
      else begin
        set_line(0, 1, 26'h70, 1'b1, 1'b1, 32'hA, 32'hB);
        set_line(1, 1, 26'h70, 1'b1, 1'b1, 32'hC, 32'hD);
      end
      run_snoop(32'h0000_1A48, 1'b1, 8);
      checks++;
      if (n_dwen + n_ccwrite + n_cctrans + n_inv + n_clean != 0) begin
        errors++; $display("FAIL miss%0d_quiet: got dWEN=%0d ccwrite=%0d cctrans=%0d inv=%0d clean=%0d expected all 0",
                           k, n_dwen, n_ccwrite, n_cctrans, n_inv, n_clean);
      end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL miss%0d_hold: got busy=%b expected 1", k, bus.busy); end
      bus.ccwait = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL miss%0d_release: got busy=%b expected 0", k, bus.busy); end
      @(negedge CLK);
    end
  endtask

  task automatic test_held_ccwait();
    clear_model(); clear_stats();
    set_line(1, 1, 26'h69, 1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0004);
    exp_q.push_back('{32'h0000_1A48, 32'hDEAD0000});
    exp_q.push_back('{32'h0000_1A4C, 32'hDEAD0004});
    run_snoop(32'h0000_1A48, 1'b0, 14);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL held_busy: got %b expected 1", bus.busy); end
    bus.ccwait = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_idle: got busy=%b expected 0", bus.busy); end
    repeat (4) @(negedge CLK);
    checks++;
    if (n_busy_rise != 1 || n_wr != 2 || n_clean != 1) begin
      errors++; $display("FAIL held_once: got lookups=%0d writes=%0d cleans=%0d expected 1 2 1", n_busy_rise, n_wr, n_clean);
    end
  endtask

  initial begin
    bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'h0; bus.dwait = 1'b0;
    clear_model(); clear_stats();
    test_reset();
    test_reset_mid_wb();
    test_dirty_read();
    test_dirty_inv_wait();
    test_clean_inv();
    test_miss();
    test_held_ccwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
